// File: rtl/div_pkg.sv
// Shared divider definitions: datapath widths and the quotient type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    localparam int DIV_Q_W       = 8;
    localparam int DIV_DIVISOR_W = 20;
    localparam int DIV_REM_W     = 28;

    typedef logic [DIV_Q_W-1:0] div_q_t;

endpackage : div_pkg

// File: rtl/div_q_mem.sv
// Quotient storage: DEPTH x DATA_W register file, one sync write, one async read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the owner decides when a write is legal.
//
// Ports:
//   clock   - write clock
//   wr_en   - write strobe, captured at the rising edge
//   wr_addr - write index
//   wr_dat  - write data
//   rd_addr - read index (combinational read)
//   rd_dat  - contents of rd_addr
//
// The array has no reset: the owning FIFO never exposes an entry that it has
// not written since reset, so clearing the storage would buy nothing.
module div_q_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_dat,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

endmodule : div_q_mem

// File: rtl/div_quotient_fifo.sv
// Result FIFO behind the divider's last stage; first-word fall-through to the consumer.
// Latency: a push at edge N is visible on q_data/q_valid during cycle N+1.
// Backpressure: none upstream (divider cannot stall); pushes into a full FIFO are dropped and flagged.
//
// Ports:
//   clock, reset_n   - clock and synchronous active-low reset
//   start_in, q_in   - quotient strobe and value from the final divider stage
//   q_ready          - consumer accepts q_data this cycle
//   clear_ovf        - clears overflow (and drop_count when present)
//   q_valid, q_data  - head of FIFO; q_data forced to 0 when empty
//   level/full/empty - registered occupancy
//   overflow         - sticky, set when a push is dropped
//   drop_count       - saturating count of dropped pushes (only with DIVQ_DROP_COUNT_EN)
//
// Build option: define DIVQ_DROP_COUNT_EN to add the drop_count port and counter.
module div_quotient_fifo
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_Q_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start_in,
    input  div_q_t                   q_in,
    input  logic                     q_ready,
    input  logic                     clear_ovf,
    output logic                     q_valid,
    output div_q_t                   q_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
`ifdef DIVQ_DROP_COUNT_EN
    ,
    output logic [7:0]               drop_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q,  level_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             ovf_q,    ovf_d;

    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [DATA_W-1:0] head_dat;

    // A pop frees the slot the same cycle, so a push into a full FIFO
    // is still accepted when the consumer is draining.
    assign pop     = !empty_q && q_ready;
    assign push_ok = start_in && (!full_q || pop);
    assign drop    = start_in && full_q && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push_ok && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LVL_W'(1);
        end

        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Writes are suppressed in the reset cycle so a quotient arriving
    // then is not captured.
    div_q_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push_ok && reset_n),
        .wr_addr (wr_ptr_q),
        .wr_dat  (q_in),
        .rd_addr (rd_ptr_q),
        .rd_dat  (head_dat)
    );

    assign q_valid  = !empty_q;
    assign q_data   = empty_q ? '0 : head_dat;
    assign level    = level_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;

`ifdef DIVQ_DROP_COUNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_ovf) begin
            drop_cnt_d = drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule : div_quotient_fifo

// File: tb/tb_div_quotient_fifo.sv
// Bench for div_quotient_fifo: directed and random traffic against a queue-based model.
// Latency: n/a.
// Backpressure: q_ready driven randomly or per directed scenario.
module tb_div_quotient_fifo;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start_in;
    logic [7:0] q_in;
    logic       q_ready;
    logic       clear_ovf;
    logic       q_valid;
    logic [7:0] q_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
`ifdef DIVQ_DROP_COUNT_EN
    logic [7:0] drop_count;
`endif

    div_quotient_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_in   (start_in),
        .q_in       (q_in),
        .q_ready    (q_ready),
        .clear_ovf  (clear_ovf),
        .q_valid    (q_valid),
        .q_data     (q_data),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
`ifdef DIVQ_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clock = ~clock;

    // Reference model: mq is the model FIFO contents, exp_q the scoreboard of
    // every accepted quotient in acceptance order.
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    int  m_ovf, m_dc;
    int  cur_level, cur_ovf, cur_dc;
    bit  mon_en = 1'b0;
    int  checks = 0;
    int  errors = 0;
    int  max_level = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares registered state and every handshake away from the edge.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("level", int'(level), cur_level);
            chk("empty", int'(empty), int'(cur_level == 0));
            chk("full", int'(full), int'(cur_level == DEPTH));
            chk("q_valid", int'(q_valid), int'(cur_level != 0));
            chk("overflow", int'(overflow), cur_ovf);
`ifdef DIVQ_DROP_COUNT_EN
            chk("drop_count", int'(drop_count), cur_dc);
`endif
            if (cur_level == 0) chk("q_data_empty", int'(q_data), 0);
            if (q_valid && q_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_unexpected", 1, 0);
                end else begin
                    chk("pop_data", int'(q_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // One clock cycle: drive inputs, predict the edge's effect, advance.
    task automatic step(input logic s, input logic [7:0] d, input logic r, input logic c);
        bit pop, acc, drp;
        start_in  = s;
        q_in      = d;
        q_ready   = r;
        clear_ovf = c;
        pop = r && (mq.size() != 0);
        acc = s && ((mq.size() < DEPTH) || pop);
        drp = s && !acc;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(d);
            exp_q.push_back(d);
        end
        if (drp) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (c) m_dc = drp ? 1 : 0;
        else if (drp && m_dc < 255) m_dc++;
        @(posedge clock);
        #1;
        cur_level = mq.size();
        cur_ovf   = m_ovf;
        cur_dc    = m_dc;
        if (cur_level > max_level) max_level = cur_level;
    endtask

    // Two reset cycles with a start pulse that must not be captured.
    task automatic do_reset();
        reset_n   = 1'b0;
        start_in  = 1'b1;
        q_in      = 8'hEE;
        q_ready   = 1'b0;
        clear_ovf = 1'b0;
        @(posedge clock);
        #1;
        mq.delete();
        exp_q.delete();
        m_ovf = 0; m_dc = 0;
        cur_level = 0; cur_ovf = 0; cur_dc = 0;
        mon_en = 1'b1;
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        start_in = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start_in = 1'b0; q_in = '0; q_ready = 1'b0; clear_ovf = 1'b0;
        m_ovf = 0; m_dc = 0; cur_level = 0; cur_ovf = 0; cur_dc = 0;

        // Reset then idle.
        do_reset();
        step(0, 8'h00, 0, 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_q_data", int'(q_data), 0);

        // Single pass.
        step(1, 8'hA5, 0, 0);
        chk("single_q_data", int'(q_data), 8'hA5);
        chk("single_level", int'(level), 1);
        step(0, 8'h00, 1, 0);
        chk("single_drained", int'(empty), 1);

        // Fill and overflow.
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
        chk("fill_full", int'(full), 1);
        chk("fill_level", int'(level), 4);
        chk("fill_ovf", int'(overflow), 1);
`ifdef DIVQ_DROP_COUNT_EN
        chk("fill_dc", int'(drop_count), 1);
`endif
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        // Full with simultaneous push/pop.
        step(0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 0);
        step(1, 8'h10, 1, 0);
        chk("pp_level", int'(level), 4);
        chk("pp_ovf", int'(overflow), 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);

        // Streaming with pointer wrap.
        max_level = 0;
        for (int i = 0; i < 20; i++) step(1, 8'(i), 1, 0);
        step(0, 8'h00, 1, 0);
        chk("stream_max_level", max_level, 1);

        // Reset mid-operation at level 3.
        for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0);
        chk("pre_reset_level", int'(level), 3);
        do_reset();
        chk("post_reset_empty", int'(empty), 1);
        step(0, 8'h00, 0, 0);

        // Clear racing a drop.
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0);
        step(1, 8'h99, 0, 1);
        chk("race_ovf", int'(overflow), 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0);
        step(0, 8'h00, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, 8'h00, 1, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_div_quotient_fifo

// File: doc/div_quotient_fifo.md
# div_quotient_fifo

Result buffer directly downstream of the divider's final pipeline stage. Captures each 8-bit quotient when that stage's start flag is high and holds it in a small FIFO. Presents the quotients to the consumer over a valid/ready handshake. The divider pipeline cannot stall, so a push into a full buffer is dropped and flagged rather than back-pressured.

## Interface
Parameters:
- DATA_W, 8, quotient width; must match the final stage's q_out width.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clock  in  1  rising-edge clock; the only clock.
- reset_n  in  1  reset, synchronous and active-low; sampled on the rising edge of clock.
- start_in  in  1  valid flag from the final stage (its start_out); high means q_in holds a quotient this cycle.
- q_in  in  DATA_W  quotient from the final stage.
- q_ready  in  1  consumer can accept q_data this cycle.
- clear_ovf  in  1  clears the sticky overflow flag.
- q_valid  out  1  q_data holds the oldest buffered quotient.
- q_data  out  DATA_W  head entry; 0 when empty.
- level  out  $clog2(DEPTH)+1  number of occupied entries.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- overflow  out  1  sticky; set when a push is dropped.
- drop_count  out  8  present only with DIVQ_DROP_COUNT_EN.

## Operation
- Push: start_in=1. Accepted if not full, or if full and a pop occurs in the same cycle. Otherwise the quotient is discarded and overflow is set.
- Pop: q_valid && q_ready. Retires the head entry.
- First-word fall-through: q_valid = !empty. q_data is read combinationally from the head of registered storage.
- Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH. level is a separate counter: +1 on push only, -1 on pop only, unchanged on push+pop.
- Simultaneous push and pop when empty: the pop is not possible (q_valid=0), so only the push takes effect.
- Simultaneous push and pop when full: both take effect. No drop, overflow unchanged, level stays DEPTH.
- clear_ovf together with a dropped push in the same cycle: set wins, overflow stays 1.
- q_in is ignored whenever start_in=0.
- Stored data is not altered: no quotient correction is done here.

## Timing
- Reset (reset_n=0 at an edge) forces:
  - q_valid=0, q_data=0, level=0, empty=1, full=0, overflow=0, drop_count=0.
  - both pointers to 0.
- Reset mid-operation discards all buffered entries. A start_in in the reset cycle is not captured.
- Push latency: a quotient pushed at edge N appears at the head (q_valid=1, if it is the only entry) after edge N, i.e. during cycle N+1.
- Pop: a handshake at edge N exposes the next entry during cycle N+1.
- Throughput: one push and one pop per cycle, sustained indefinitely.
- level, full, empty and overflow are registered and update at the same edge as the pointers.

## Configuration
- DIVQ_DROP_COUNT_EN defined:
  - adds the drop_count output port.
  - 8-bit counter increments on every dropped push and saturates at 255.
  - cleared by reset and by clear_ovf.
  - if clear_ovf and a drop coincide, the result is 1.
- DIVQ_DROP_COUNT_EN undefined: no port and no counter. All other behaviour is identical.

## Structure
- Shared package div_pkg holds:
  - localparam DIV_Q_W = 8.
  - localparam DIV_DIVISOR_W = 20.
  - localparam DIV_REM_W = 28.
  - typedef div_q_t (logic [DIV_Q_W-1:0]), used for q_in and q_data.
- One sub-module, div_q_mem: DEPTH×DATA_W register file with one synchronous write port, one asynchronous read port, and no reset on the storage array.
- Pointers, level, flags and drop counter live in div_quotient_fifo.

## Test plan
- Reset then idle: hold reset_n=0 for 2 cycles, then release with start_in=0 -> all outputs at reset values; empty=1, q_data=0.
- Single pass: push 0xA5 with q_ready=0 -> next cycle q_valid=1, q_data=0xA5, level=1. Then q_ready=1 for one cycle -> empty=1.
- Fill and overflow (DEPTH=4), q_ready=0:
  - push 0x01..0x05 -> full=1, level=4, overflow=1.
  - drain -> yields 0x01..0x04 in order.
  - drop_count=1 when the macro is enabled.
- Full with simultaneous push/pop: while full, push 0x10 with q_ready=1 -> no drop, level stays 4, overflow unchanged, 0x10 emerges last.
- Streaming with wrap: 20 back-to-back pushes 0x00..0x13 with q_ready=1 -> outputs are 0x00..0x13 each one cycle after push, level never exceeds 1.
- Reset mid-operation with clear race:
  - with level=3, assert reset_n=0 -> next cycle empty=1.
  - separately, clear_ovf coincident with a drop -> overflow stays 1.
